// File: rtl/aes_pkg.sv
// AES shared definitions: round counts, FSM state
// encoding, S-box table and word helpers.
package aes_pkg;

  localparam int NR = 10;
  localparam int NK = 4;

  localparam logic [3:0] LAST_RND = 4'(NR);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(
    input logic [7:0] x
  );
    return SBOX[x];
  endfunction

  function automatic logic [31:0] rot_word(
    input logic [31:0] w
  );
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/sub_word.sv
// AES SubWord: byte-wise S-box substitution
// of one 32-bit word, purely combinational.
module sub_word
  import aes_pkg::*;
(
  input  logic [31:0] w,
  output logic [31:0] s
);

  // four independent byte lookups
  always_comb begin
    s = {sbox(w[31:24]), sbox(w[23:16]),
         sbox(w[15:8]),  sbox(w[7:0])};
  end

endmodule

// File: rtl/key_sched_ctrl.sv
// AES-128 key-schedule controller: drives the
// rcon ROM, expands the key, serves round keys.
module key_sched_ctrl
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic [3:0]   rcon_addr,
  input  logic [31:0]  rcon_data,
  output logic         busy,
  output logic         done,
  input  logic [3:0]   rk_addr,
  output logic [127:0] rk_data
);

  state_t       state;
  logic [3:0]   round;
  logic [127:0] rk [0:NR];

  logic [3:0]   pidx;
  logic [127:0] prev;
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rw, sw, t;
  logic [31:0]  w4, w5, w6, w7;

  assign rcon_addr = round;

  // previous round key feeds this round's expansion
  always_comb begin
    pidx = (round == 4'd0) ? 4'd0 : round - 4'd1;
    prev = rk[pidx];
    {w0, w1, w2, w3} = prev;
    rw = rot_word(w3);
  end

  sub_word u_sub (
    .w (rw),
    .s (sw)
  );

  // XOR chain producing the next four words
  always_comb begin
    t  = sw ^ rcon_data;
    w4 = w0 ^ t;
    w5 = w4 ^ w1;
    w6 = w5 ^ w2;
    w7 = w6 ^ w3;
  end

  // control FSM with registered busy/done
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      round <= 4'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            round <= 4'd1;
            busy  <= 1'b1;
            state <= ADDR;
          end
        end
        ADDR: begin
          state <= CALC;
        end
        CALC: begin
          if (round == LAST_RND) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            round <= round + 4'd1;
            state <= ADDR;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // round-key register file: load and expand
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i <= NR; i++) begin
        rk[i] <= '0;
      end
    end else begin
      if (state == IDLE && start) begin
        rk[0] <= key_in;
      end
      if (state == CALC) begin
        rk[round] <= {w4, w5, w6, w7};
      end
    end
  end

  // registered read port, zero beyond the last key
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rk_data <= '0;
    end else if (rk_addr <= LAST_RND) begin
      rk_data <= rk[rk_addr];
    end else begin
      rk_data <= '0;
    end
  end

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Directed bench for key_sched_ctrl with a
// 1-cycle registered rcon ROM model.
module tb_key_sched_ctrl;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] key_in;
  logic [3:0]   rcon_addr;
  logic [31:0]  rcon_data;
  logic         busy;
  logic         done;
  logic [3:0]   rk_addr;
  logic [127:0] rk_data;

  int nchk;
  int nerr;

  localparam logic [127:0] KF   =
    128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KF1  =
    128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] KF10 =
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KZ   = 128'h0;
  localparam logic [127:0] KZ1  =
    128'h62636363626363636263636362636363;
  localparam logic [127:0] KZ10 =
    128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  key_sched_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .key_in    (key_in),
    .rcon_addr (rcon_addr),
    .rcon_data (rcon_data),
    .busy      (busy),
    .done      (done),
    .rk_addr   (rk_addr),
    .rk_data   (rk_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rc(input logic [3:0] a);
    case (a)
      4'd1:  return 8'h01;
      4'd2:  return 8'h02;
      4'd3:  return 8'h04;
      4'd4:  return 8'h08;
      4'd5:  return 8'h10;
      4'd6:  return 8'h20;
      4'd7:  return 8'h40;
      4'd8:  return 8'h80;
      4'd9:  return 8'h1b;
      4'd10: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk) rcon_data <= {rc(rcon_addr), 24'h0};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic rd(input string tag,
                    input logic [3:0] a,
                    input logic [127:0] exp);
    rk_addr = a;
    tick;
    chk(tag, rk_data, exp);
  endtask

  task automatic run(input logic [127:0] key,
                     input logic [127:0] exp10,
                     input int stray_at,
                     input logic chk_addr);
    int dc;
    dc = 0;
    key_in  = key;
    start   = 1'b1;
    rk_addr = 4'd0;
    tick;
    start = 1'b0;
    for (int c = 1; c <= 30 && dc == 0; c++) begin
      if (c == stray_at) begin
        start  = 1'b1;
        key_in = ~key;
      end else begin
        start = 1'b0;
      end
      chk("busy_on", busy, 1'b1);
      if (c == 2) chk("rd0_busy", rk_data, key);
      if (chk_addr && c <= 20)
        chk("rcon_addr", rcon_addr, 128'((c + 1) / 2));
      if (done) begin
        dc = c;
        rk_addr = 4'd10;
      end
      tick;
    end
    start = 1'b0;
    chk("done_cyc", 128'(dc), 128'd21);
    chk("rk10_rd", rk_data, exp10);
    chk("busy_off", busy, 1'b0);
    chk("done_off", done, 1'b0);
  endtask

  initial begin
    nchk    = 0;
    nerr    = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    key_in  = '0;
    rk_addr = 4'd0;
    repeat (3) tick;
    rst_n = 1'b1;
    tick;

    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_rcon", rcon_addr, 4'd0);
    chk("rst_rkd", rk_data, '0);

    run(KF, KF10, 0, 1'b1);
    rd("fips_rk1", 4'd1, KF1);
    rd("fips_rk10", 4'd10, KF10);

    run(KZ, KZ10, 0, 1'b0);
    rd("zero_rk1", 4'd1, KZ1);

    run(KF, KF10, 5, 1'b0);
    rd("stray_rk1", 4'd1, KF1);
    rd("stray_rk0", 4'd0, KF);

    rd("rd_addr11", 4'd11, '0);
    rd("rd_addr15", 4'd15, '0);

    key_in  = KZ;
    start   = 1'b1;
    rk_addr = 4'd1;
    tick;
    start = 1'b0;
    repeat (8) tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_rcon", rcon_addr, 4'd0);
    chk("abort_rkd", rk_data, '0);
    for (int i = 0; i <= 10; i++) begin
      rd("abort_rd", 4'(i), '0);
    end
    run(KF, KF10, 0, 1'b0);
    rd("post_rk1", 4'd1, KF1);

    run(KF, KF10, 0, 1'b0);
    run(KZ, KZ10, 0, 1'b0);
    rd("b2b_rk1", 4'd1, KZ1);
    rd("b2b_rk0", 4'd0, KZ);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             nchk, nerr);
    $finish;
  end

endmodule
